mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter between instruction fetch and data access.
// A data request wins over a fetch; each requester keeps a done flag and a
// result buffer so the pipeline can sit in a stall without reissuing the
// access. A wait counter aborts a transaction that is never acknowledged.
module mem_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, IFETCH, DATA} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        if_valid_q, if_valid_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] if_buf_q, if_buf_d;
    logic [31:0] mem_buf_q, mem_buf_d;

    logic        if_pend, mem_pend;
    logic        busy, timeout, done;
    logic        if_done, mem_done;
    logic [31:0] done_data;
    logic        stall_unused;

    // Only the IF and MEM stall bits gate the done flags.
    assign stall_unused = ^{stall_i[5], stall_i[3:2], stall_i[0]};

    assign if_pend   = if_ce_i & ~if_valid_q;
    assign mem_pend  = mem_ce_i & ~mem_valid_q;
    assign busy      = (state_q != IDLE);
    // A timed-out transaction completes like an ack but returns zero data.
    assign timeout   = busy & ~bus_ack_i & (wait_cnt_q == 4'(MAX_WAIT));
    assign done      = busy & (bus_ack_i | timeout);
    assign done_data = bus_ack_i ? bus_rdata_i : 32'h0;
    assign if_done   = done & (state_q == IFETCH);
    assign mem_done  = done & (state_q == DATA);

    // State, counter, done flags and buffers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_buf_q    <= 32'h0;
            mem_buf_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            if_buf_q    <= if_buf_d;
            mem_buf_q   <= mem_buf_d;
        end
    end

    // Next state: fixed priority to data, back-to-back handoff on completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_pend)     state_d = DATA;
                else if (if_pend) state_d = IFETCH;
            end
            IFETCH: if (done) state_d = mem_pend ? DATA : IDLE;
            DATA:   if (done) state_d = if_pend ? IFETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Wait counter restarts on every state entry, counts unacked busy cycles.
    always_comb begin
        wait_cnt_d = 4'd0;
        if (busy && !done) wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Done flags and buffers; a released stall clears the flag and wins over a set.
    always_comb begin
        if_valid_d  = if_valid_q;
        mem_valid_d = mem_valid_q;
        if_buf_d    = if_buf_q;
        mem_buf_d   = mem_buf_q;
        if (if_done) begin
            if_valid_d = 1'b1;
            if_buf_d   = done_data;
        end
        if (mem_done) begin
            mem_valid_d = 1'b1;
            mem_buf_d   = done_data;
        end
        if (!stall_i[1]) if_valid_d  = 1'b0;
        if (!stall_i[4]) mem_valid_d = 1'b0;
    end

    // Shared port drive follows the granted requester combinationally.
    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = 32'h0;
        bus_sel_o   = 4'h0;
        bus_wdata_o = 32'h0;
        case (state_q)
            IFETCH: begin
                bus_req_o  = 1'b1;
                bus_addr_o = if_addr_i;
                bus_sel_o  = 4'hF;
            end
            DATA: begin
                bus_req_o   = 1'b1;
                bus_we_o    = mem_we_i;
                bus_addr_o  = mem_addr_i;
                bus_sel_o   = mem_sel_i;
                bus_wdata_o = mem_wdata_i;
            end
            default: ;
        endcase
    end

    assign bus_err_o = timeout;

    // Stall requests are masked while reset is asserted.
    assign if_stallreq_o  = rst & if_ce_i & ~if_valid_q
                            & ~((state_q == IFETCH) & bus_ack_i);
    assign mem_stallreq_o = rst & mem_ce_i & ~mem_valid_q
                            & ~((state_q == DATA) & bus_ack_i);

    assign if_data_o   = if_valid_q ? if_buf_q :
                         (((state_q == IFETCH) & bus_ack_i) ? bus_rdata_i : 32'h0);
    assign mem_rdata_o = mem_valid_q ? mem_buf_q :
                         (((state_q == DATA) & bus_ack_i) ? bus_rdata_i : 32'h0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver issues request sets, the
// reference order (data before fetch) and expected results are queued, and a
// negedge monitor checks every bus cycle and every returned result.
module tb_mem_arbiter;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_stallreq_o(if_stallreq_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_stallreq_o(mem_stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_if;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        bit          noack;
    } bus_exp_t;

    typedef struct {
        int          lat;
        bit          noack;
        logic [31:0] data;
    } slv_t;

    bus_exp_t    bus_q[$];
    slv_t        slv_q[$];
    logic [31:0] if_exp_q[$];
    logic [31:0] mem_exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Bus slave: acks after lat extra cycles, or never (forcing a timeout).
    bit   slv_busy = 1'b0;
    int   slv_cnt  = 0;
    slv_t slv_cur;
    initial begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                slv_busy  = 1'b0;
                bus_ack_i = 1'b0;
            end else begin
                if (bus_ack_i) begin
                    bus_ack_i = 1'b0;
                    slv_busy  = 1'b0;
                end
                if (slv_busy && slv_cur.noack && slv_cnt == MAX_WAIT + 1) slv_busy = 1'b0;
                bus_rdata_i = $urandom;
                if (!slv_busy && bus_req_o && slv_q.size() > 0) begin
                    slv_cur  = slv_q.pop_front();
                    slv_busy = 1'b1;
                    slv_cnt  = 0;
                end
                if (slv_busy) begin
                    if (!slv_cur.noack && slv_cnt == slv_cur.lat) begin
                        bus_ack_i   = 1'b1;
                        bus_rdata_i = slv_cur.data;
                    end
                    slv_cnt++;
                end
            end
        end
    end

    // Monitor: bus fields every busy cycle, completion type, returned data.
    always @(negedge clk) begin
        if (rst) begin
            if (bus_req_o) begin
                if (bus_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL bus_unexpected: bus_req_o=1 addr %h, expected no request", bus_addr_o);
                end else begin
                    check("bus_addr", bus_addr_o, bus_q[0].addr);
                    check("bus_we", 32'(bus_we_o), 32'(bus_q[0].we));
                    check("bus_sel", 32'(bus_sel_o), 32'(bus_q[0].sel));
                    if (!bus_q[0].is_if) check("bus_wdata", bus_wdata_o, bus_q[0].wdata);
                    if (bus_ack_i || bus_err_o) begin
                        check("bus_err", 32'(bus_err_o), 32'(bus_q[0].noack));
                        void'(bus_q.pop_front());
                    end
                end
            end else begin
                check("bus_err_idle", 32'(bus_err_o), 32'h0);
            end
            if (if_ce_i && !if_stallreq_o && if_exp_q.size() > 0)
                check("if_data", if_data_o, if_exp_q.pop_front());
            if (mem_ce_i && !mem_stallreq_o && mem_exp_q.size() > 0)
                check("mem_rdata", mem_rdata_o, mem_exp_q.pop_front());
        end
    end

    task automatic flush_and_reset();
        rst = 1'b0;
        bus_q.delete();
        slv_q.delete();
        if_exp_q.delete();
        mem_exp_q.delete();
        if_ce_i  = 1'b0;
        mem_ce_i = 1'b0;
        stall_i  = 6'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One request set: queue the reference outcome, drive, wait, then hold.
    task automatic run(input bit do_if, input bit do_mem,
                       input logic [31:0] ia, input logic [31:0] ma,
                       input bit mwe, input logic [3:0] msel, input logic [31:0] mwd,
                       input slv_t ms, input slv_t is, input int hold);
        int          exp_span = 0;
        int          cyc = 0;
        int          first = -1;
        int          last = -1;
        bit          done = 1'b0;
        logic [31:0] exp_if = 32'h0;
        logic [31:0] exp_mem = 32'h0;
        @(posedge clk);
        #1;
        if (do_mem) begin
            exp_mem = ms.noack ? 32'h0 : ms.data;
            bus_q.push_back('{is_if: 1'b0, addr: ma, we: mwe, sel: msel, wdata: mwd, noack: ms.noack});
            slv_q.push_back(ms);
            mem_exp_q.push_back(exp_mem);
            exp_span += ms.noack ? MAX_WAIT + 1 : ms.lat + 1;
        end
        if (do_if) begin
            exp_if = is.noack ? 32'h0 : is.data;
            bus_q.push_back('{is_if: 1'b1, addr: ia, we: 1'b0, sel: 4'hF, wdata: 32'h0, noack: is.noack});
            slv_q.push_back(is);
            if_exp_q.push_back(exp_if);
            exp_span += is.noack ? MAX_WAIT + 1 : is.lat + 1;
        end
        if_ce_i     = do_if;
        if_addr_i   = ia;
        mem_ce_i    = do_mem;
        mem_we_i    = mwe;
        mem_addr_i  = ma;
        mem_sel_i   = msel;
        mem_wdata_i = mwd;
        stall_i     = 6'b011111;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus_req_o && first < 0) first = cyc;
            if (bus_req_o && (bus_ack_i || bus_err_o)) last = cyc;
            if (!if_stallreq_o && !mem_stallreq_o) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_bound: stallreq still high after %0d cycles, expected low", cyc);
            flush_and_reset();
        end else begin
            check("busy_span", last - first + 1, exp_span);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_no_req", 32'(bus_req_o), 32'h0);
                if (do_if)  check("hold_if_data", if_data_o, exp_if);
                if (do_mem) check("hold_mem_rdata", mem_rdata_o, exp_mem);
            end
        end
        @(posedge clk);
        #1;
        if_ce_i  = 1'b0;
        mem_ce_i = 1'b0;
        stall_i  = 6'b0;
        @(posedge clk);
    endtask

    initial begin
        slv_t s0, s1;
        rst = 1'b0;
        stall_i = 6'b0;
        if_ce_i = 1'b1;
        if_addr_i = 32'h0;
        mem_ce_i = 1'b1;
        mem_we_i = 1'b0;
        mem_addr_i = 32'h0;
        mem_sel_i = 4'h0;
        mem_wdata_i = 32'h0;

        #12;
        check("rst_bus_req", 32'(bus_req_o), 32'h0);
        check("rst_if_stallreq", 32'(if_stallreq_o), 32'h0);
        check("rst_mem_stallreq", 32'(mem_stallreq_o), 32'h0);
        check("rst_if_data", if_data_o, 32'h0);
        check("rst_mem_rdata", mem_rdata_o, 32'h0);
        check("rst_bus_err", 32'(bus_err_o), 32'h0);
        if_ce_i  = 1'b0;
        mem_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        s0 = '{lat: 0, noack: 1'b0, data: 32'h0};
        // Lone fetch, then a fetch held across a stall.
        s1 = '{lat: 2, noack: 1'b0, data: 32'h3C010001};
        run(1, 0, 32'h100, 32'h0, 0, 4'h0, 32'h0, s0, s1, 0);
        s1 = '{lat: 1, noack: 1'b0, data: 32'h11111111};
        run(1, 0, 32'h104, 32'h0, 0, 4'h0, 32'h0, s0, s1, 3);
        // Simultaneous data read and fetch.
        s0 = '{lat: 1, noack: 1'b0, data: 32'hDEADBEEF};
        s1 = '{lat: 1, noack: 1'b0, data: 32'h24020005};
        run(1, 1, 32'h104, 32'h200, 0, 4'hF, 32'h0, s0, s1, 1);
        // Store.
        s0 = '{lat: 3, noack: 1'b0, data: 32'h12345678};
        run(0, 1, 32'h0, 32'h300, 1, 4'b0011, 32'hAABBCCDD, s0, s1, 0);
        // Timeout on a data read.
        s0 = '{lat: 0, noack: 1'b1, data: 32'h0};
        run(0, 1, 32'h0, 32'h400, 0, 4'hF, 32'h0, s0, s1, 2);

        for (int i = 0; i < 50; i++) begin
            bit di, dm;
            di = 1'($urandom_range(0, 1));
            dm = 1'($urandom_range(0, 1));
            if (!di && !dm) di = 1'b1;
            s0 = '{lat: int'($urandom_range(0, 3)), noack: ($urandom_range(0, 9) == 0), data: $urandom};
            s1 = '{lat: int'($urandom_range(0, 3)), noack: ($urandom_range(0, 9) == 0), data: $urandom};
            run(di, dm, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                $urandom, s0, s1, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a data transaction.
        @(posedge clk);
        #1;
        bus_q.push_back('{is_if: 1'b0, addr: 32'h500, we: 1'b0, sel: 4'hF, wdata: 32'h0, noack: 1'b1});
        slv_q.push_back('{lat: 0, noack: 1'b1, data: 32'h0});
        mem_ce_i   = 1'b1;
        mem_addr_i = 32'h500;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_wdata_i = 32'h0;
        if_ce_i    = 1'b1;
        if_addr_i  = 32'h600;
        stall_i    = 6'b011111;
        repeat (4) @(negedge clk);
        check("mid_bus_req_before", 32'(bus_req_o), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_bus_req", 32'(bus_req_o), 32'h0);
        check("mid_rst_if_stallreq", 32'(if_stallreq_o), 32'h0);
        check("mid_rst_mem_stallreq", 32'(mem_stallreq_o), 32'h0);
        check("mid_rst_bus_addr", bus_addr_o, 32'h0);
        flush_and_reset();
        #1;
        check("post_rst_bus_req", 32'(bus_req_o), 32'h0);

        // Service resumes right after reset release.
        s1 = '{lat: 0, noack: 1'b0, data: 32'hCAFEF00D};
        run(1, 0, 32'h700, 32'h0, 0, 4'h0, 32'h0, s0, s1, 1);

        repeat (3) @(posedge clk);
        if (bus_q.size() != 0 || if_exp_q.size() != 0 || mem_exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover: %0d bus / %0d if / %0d mem expectations unconsumed, expected 0",
                     bus_q.size(), if_exp_q.size(), mem_exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
